csa4: RTL and testbench
=======================

CSA4 -- requirements
Module: csa4

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 a  input  4  addend A, unsigned.
REQ-005 b  input  4  addend B, unsigned.
REQ-006 cin  input  1  carry-in.
REQ-007 cout  output  1  registered carry-out of the 4-bit sum.
REQ-008 sum  output  4  registered 4-bit sum.
REQ-009 Port order SHALL be clk, rst_n, a, b, cin, cout, sum, so positional instantiation maps (a, b, cin, cout, sum) after clk and rst_n.

Function
REQ-010 The combinational result SHALL be {cout_n, sum_n} = a + b + cin, a 5-bit unsigned value; no overflow is possible.
REQ-011 The adder SHALL be a carry-select structure:
- low block: bits [1:0], two full adders in ripple, carry-in = cin.
- high block: bits [3:2], computed twice, once with carry-in 0 and once with carry-in 1.
REQ-012 The low block's carry-out SHALL select, through 2:1 muxes, both the high-block sum bits and the final carry-out.
REQ-013 Full adders SHALL be built from gate-level XOR/AND/OR logic; no behavioural "+" inside the adder datapath.
REQ-014 On each rising clk edge with rst_n high, sum <= sum_n and cout <= cout_n.
- Latency is exactly 1 cycle from input change to output.
- Inputs SHALL be sampled only at the rising edge.
REQ-015 Inputs may change at any time between edges, e.g. on the falling edge; the outputs SHALL reflect only the values present at the rising edge.
REQ-016 Outputs SHALL hold their value between rising edges regardless of input activity.
REQ-017 Boundary cases:
- 4'hF + 4'hF + 1 = sum 4'hF, cout 1.
- 4'h0 + 4'h0 + 0 = sum 4'h0, cout 0.
- 4'hF + 4'h0 + 1 wraps to sum 4'h0, cout 1.
REQ-018 Any X or Z on an input SHALL NOT be masked; no input qualification is performed.

Reset
REQ-019 When rst_n is low, sum SHALL be 4'h0 and cout SHALL be 0 immediately, without waiting for a clk edge.
REQ-020 While rst_n is low, rising clk edges SHALL NOT update the outputs.
REQ-021 The first rising edge after rst_n deasserts SHALL register the current inputs normally.
REQ-022 Reset asserted mid-operation SHALL discard the registered result; no pending state is retained.

Verification
REQ-023 Reset: rst_n=0 with a=4'h5, b=4'h3, cin=1 and clk toggling -> sum=4'h0, cout=0 throughout; release rst_n -> after one edge sum=4'h9, cout=0.
REQ-024 Latency: a=4'h1, b=4'h1, cin=0 applied on the falling edge -> sum=4'h2, cout=0 after the next rising edge, not before.
REQ-025 Carry select path: a=4'h3, b=4'h1, cin=0 (low-block carry=1) -> sum=4'h4, cout=0; a=4'hC, b=4'h4, cin=0 -> sum=4'h0, cout=1.
REQ-026 Extremes: a=4'hF, b=4'hF, cin=1 -> sum=4'hF, cout=1; a=4'hF, b=4'h0, cin=1 -> sum=4'h0, cout=1.
REQ-027 Exhaustive sweep: all 512 combinations of (a, b, cin), changed on falling edges -> each rising edge's registered {cout, sum} equals a + b + cin of the sampled inputs.
REQ-028 Async reset mid-run: drop rst_n between clock edges while sum=4'hA -> sum=4'h0 and cout=0 before the next rising edge.

Source files
------------

// File: rtl/csa4.sv
// 4-bit carry-select adder with registered outputs.
// Low 2 bits ripple from cin; high 2 bits are precomputed for both carries and selected.
module csa4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic       cout,
  output logic [3:0] sum
);

  // Gate-level full adder, returns {carry, sum}
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    logic p;
    p = x ^ y;
    full_add = {(x & y) | (c & p), p ^ c};
  endfunction

  function automatic logic mux2(input logic sel, input logic d0, input logic d1);
    mux2 = (~sel & d0) | (sel & d1);
  endfunction

  logic [1:0] lo0_p0, lo1_p0;
  logic [1:0] hz0_p0, hz1_p0;
  logic [1:0] ho0_p0, ho1_p0;
  logic       lo_carry_p0;
  logic [3:0] sum_p0;
  logic       cout_p0;

  // Stage p0: combinational carry-select datapath
  always_comb begin
    lo0_p0      = full_add(a[0], b[0], cin);
    lo1_p0      = full_add(a[1], b[1], lo0_p0[1]);
    lo_carry_p0 = lo1_p0[1];

    hz0_p0 = full_add(a[2], b[2], 1'b0);
    hz1_p0 = full_add(a[3], b[3], hz0_p0[1]);
    ho0_p0 = full_add(a[2], b[2], 1'b1);
    ho1_p0 = full_add(a[3], b[3], ho0_p0[1]);

    sum_p0[0] = lo0_p0[0];
    sum_p0[1] = lo1_p0[0];
    sum_p0[2] = mux2(lo_carry_p0, hz0_p0[0], ho0_p0[0]);
    sum_p0[3] = mux2(lo_carry_p0, hz1_p0[0], ho1_p0[0]);
    cout_p0   = mux2(lo_carry_p0, hz1_p0[1], ho1_p0[1]);
  end

  // Stage p1: output register, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= 4'h0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_p0;
      cout <= cout_p0;
    end
  end

endmodule

// File: tb/tb_csa4.sv
// Scoreboard bench for csa4: stimulus pushes expected a+b+cin, a monitor pops after each rising edge.
module tb_csa4;
  logic       clk;
  logic       rst_n;
  logic [3:0] a, b;
  logic       cin;
  logic       cout;
  logic [3:0] sum;

  int checks   = 0;
  int failures = 0;
  logic [4:0] exp_q[$];

  csa4 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .cout (cout),
    .sum  (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got {cout,sum}=%h required %h at t=%0t", name, act, req, $time);
    end
  endtask

  // Apply inputs on the falling edge and record the reference result
  task automatic drive(input logic [3:0] va, input logic [3:0] vb, input logic vc);
    int total;
    @(negedge clk);
    a = va; b = vb; cin = vc;
    total = int'(va) + int'(vb) + int'(vc);
    exp_q.push_back(total[4:0]);
  endtask

  // Monitor: every registering edge consumes one expected value
  initial begin
    logic [4:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", {cout, sum}, e);
      end
    end
  end

  initial begin
    int wait_cycles;
    rst_n = 1'b0;
    a = 4'h5; b = 4'h3; cin = 1'b1;

    // Reset held with clock toggling
    #1 check("reset_async", {cout, sum}, 5'h00);
    repeat (3) begin
      @(posedge clk); #1;
      check("reset_hold", {cout, sum}, 5'h00);
    end

    // Release: first edge registers 5+3+1
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(5'h09);

    // Latency: new inputs must not appear before the next rising edge
    @(negedge clk);
    a = 4'h1; b = 4'h1; cin = 1'b0;
    exp_q.push_back(5'h02);
    #1 check("latency_hold", {cout, sum}, 5'h09);

    // Carry-select paths and extremes
    drive(4'h3, 4'h1, 1'b0);
    drive(4'hC, 4'h4, 1'b0);
    drive(4'hF, 4'hF, 1'b1);
    drive(4'h0, 4'h0, 1'b0);
    drive(4'hF, 4'h0, 1'b1);

    // Exhaustive sweep
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = i[8:0];
      drive(v[8:5], v[4:1], v[0]);
    end

    // Random stimulus with mid-cycle input noise that must not be sampled
    for (int i = 0; i < 150; i++) begin
      drive(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
      @(posedge clk); #3;
      a = 4'($urandom_range(15)); b = 4'($urandom_range(15)); cin = 1'($urandom_range(1));
      #1 check("hold_between_edges", {cout, sum}, exp_last());
    end

    // Async reset mid-run while sum = 4'hA
    drive(4'h7, 4'h3, 1'b0);
    @(posedge clk); #3;
    check("pre_reset_value", {cout, sum}, 5'h0A);
    rst_n = 1'b0;
    #1 check("reset_midrun", {cout, sum}, 5'h00);
    a = 4'hF; b = 4'hF; cin = 1'b1;
    @(posedge clk); #1;
    check("reset_blocks_edge", {cout, sum}, 5'h00);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(5'h1F);
    drive(4'h2, 4'h2, 1'b0);

    // Drain the scoreboard with a bounded wait
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk); #2;
      wait_cycles++;
    end
    check("scoreboard_drained", 5'(exp_q.size()), 5'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Value most recently driven, for the between-edges hold check
  logic [4:0] last_exp;
  always @(negedge clk) begin
    #0;
    if (exp_q.size() > 0) last_exp = exp_q[exp_q.size()-1];
  end
  function automatic logic [4:0] exp_last();
    return last_exp;
  endfunction

endmodule
